// File: rtl/census_cost.sv
`default_nettype none
// ============================================================================
// census_cost : Hamming cost of each left census code against the last
//               MAX_DISP right codes, two-stage pipeline.   Revision 1.0
// ============================================================================
module census_cost #(
  parameter int CODE_W   = 8,
  parameter int MAX_DISP = 16,
  parameter int COST_W   = 4,
  parameter int X_W      = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         sol,
  input  logic [CODE_W-1:0]            census_l,
  input  logic [CODE_W-1:0]            census_r,
  output logic                         out_valid,
  output logic                         out_sol,
  output logic [X_W-1:0]               out_x,
  output logic [MAX_DISP*COST_W-1:0]   cost_bus
);

  localparam int              c_f_w      = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;
  localparam logic [c_f_w-1:0]  c_f_max    = c_f_w'(MAX_DISP - 1);
  localparam logic [X_W-1:0]    c_x_max    = '1;
  localparam logic [COST_W-1:0] c_cost_max = COST_W'(CODE_W);

  function automatic logic [COST_W-1:0] popcount(input logic [CODE_W-1:0] v);
    logic [COST_W-1:0] n;
    n = '0;
    for (int i = 0; i < CODE_W; i++) n = n + COST_W'(v[i]);
    return n;
  endfunction

  // r_hist[k] holds the right code of column x-1-k; the live census_r is R[0]
  logic [CODE_W-1:0]          r_hist [MAX_DISP-1];
  logic [X_W-1:0]             r_next_x;
  logic [c_f_w-1:0]           r_next_f;

  logic                       r_s1_valid;
  logic                       r_s1_sol;
  logic [X_W-1:0]             r_s1_x;
  logic [MAX_DISP-1:0]        r_s1_mask;
  logic [CODE_W-1:0]          r_s1_xor [MAX_DISP];

  logic [X_W-1:0]             w_cur_x;
  logic [c_f_w-1:0]           w_cur_f;
  logic [CODE_W-1:0]          w_cand [MAX_DISP];
  logic [MAX_DISP-1:0]        w_invalid;
  logic [MAX_DISP*COST_W-1:0] w_cost;

  // A start-of-line beat discards whatever history came before it
  assign w_cur_x = sol ? '0 : r_next_x;
  assign w_cur_f = sol ? '0 : r_next_f;

  for (genvar d = 0; d < MAX_DISP; d++) begin : g_disp
    if (d == 0) begin : g_live
      assign w_cand[d] = census_r;
    end else begin : g_hist
      assign w_cand[d] = r_hist[d-1];
    end
    assign w_invalid[d] = d > int'(w_cur_f);
    assign w_cost[d*COST_W +: COST_W] = r_s1_mask[d] ? c_cost_max : popcount(r_s1_xor[d]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DISP-1; i++) r_hist[i] <= '0;
      for (int i = 0; i < MAX_DISP; i++) r_s1_xor[i] <= '0;
      r_next_x   <= '0;
      r_next_f   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_sol   <= 1'b0;
      r_s1_x     <= '0;
      r_s1_mask  <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_hist[0] <= census_r;
        for (int i = 1; i < MAX_DISP-1; i++) r_hist[i] <= r_hist[i-1];
        r_next_x <= (w_cur_x == c_x_max) ? w_cur_x : w_cur_x + 1'b1;
        r_next_f <= (w_cur_f == c_f_max) ? w_cur_f : w_cur_f + 1'b1;
        for (int i = 0; i < MAX_DISP; i++) r_s1_xor[i] <= census_l ^ w_cand[i];
        r_s1_mask <= w_invalid;
        r_s1_x    <= w_cur_x;
        r_s1_sol  <= sol;
      end
    end
  end

  // Output registers only move on valid beats so idle cycles hold the last pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_x     <= '0;
      cost_bus  <= '0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_sol  <= r_s1_sol;
        out_x    <= r_s1_x;
        cost_bus <= w_cost;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_census_cost.sv
`default_nettype none
// ============================================================================
// tb_census_cost : directed self-checking bench for census_cost.  Revision 1.0
// ============================================================================
module tb_census_cost;
  localparam int CODE_W = 8, MAX_DISP = 16, COST_W = 4, X_W = 11;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       sol = 1'b0;
  logic [CODE_W-1:0]          census_l = '0;
  logic [CODE_W-1:0]          census_r = '0;
  logic                       out_valid;
  logic                       out_sol;
  logic [X_W-1:0]             out_x;
  logic [MAX_DISP*COST_W-1:0] cost_bus;

  int checks = 0;
  int failures = 0;

  census_cost #(.CODE_W(CODE_W), .MAX_DISP(MAX_DISP), .COST_W(COST_W), .X_W(X_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sol(sol),
    .census_l(census_l), .census_r(census_r),
    .out_valid(out_valid), .out_sol(out_sol), .out_x(out_x), .cost_bus(cost_bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] l, input logic [7:0] r);
    in_valid = v;
    sol      = s;
    census_l = l;
    census_r = r;
  endtask

  // Expected bus when left and right codes are identical: 0 where history exists, 8 past the edge
  function automatic logic [63:0] match_bus(input int x);
    logic [63:0] b;
    for (int d = 0; d < 16; d++) b[d*4 +: 4] = (d <= x) ? 4'd0 : 4'd8;
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 1'b1, 8'hA5, 8'h5A);
      step();
      checks++;
      if (out_valid !== 1'b0 || cost_bus !== 64'd0 || out_x !== 11'd0) begin
        failures++;
        $display("FAIL reset_hold%0d: out_valid=%b out_x=%0d cost_bus=%h, want 0 0 0", i, out_valid, out_x, cost_bus);
      end
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || cost_bus !== 64'd0 || out_x !== 11'd0 || out_sol !== 1'b0) begin
        failures++;
        $display("FAIL reset_release%0d: out_valid=%b out_x=%0d out_sol=%b cost_bus=%h, want 0 0 0 0",
                 i, out_valid, out_x, out_sol, cost_bus);
      end
    end
  endtask

  task automatic test_identical();
    for (int k = 0; k < 23; k++) begin
      int x;
      x = k - 2;
      checks++;
      if (k >= 2 && x < 20) begin
        if (out_valid !== 1'b1 || out_x !== 11'(x) || out_sol !== (x == 0) || cost_bus !== match_bus(x)) begin
          failures++;
          $display("FAIL identical_x%0d: out_valid=%b out_x=%0d out_sol=%b cost_bus=%h, want 1 %0d %b %h",
                   x, out_valid, out_x, out_sol, cost_bus, x, (x == 0), match_bus(x));
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL identical_idle_k%0d: out_valid=%b, want 0", k, out_valid);
      end
      drive(k < 20, k == 0, 8'hA5, 8'hA5);
      step();
    end
  endtask

  // census_r = column, census_l = 0x0F; gap idle cycles follow every beat
  task automatic test_arith(input int gap);
    int period, ncyc, last_x;
    bit have_last;
    logic [63:0] exp_bus;
    period = gap + 1;
    ncyc = 8 * period + 3;
    have_last = 0;
    last_x = 0;
    for (int c = 0; c < ncyc; c++) begin
      bit ev, dv;
      int ex, bi;
      ev = (c >= 2) && ((c - 2) % period == 0) && ((c - 2) / period < 8);
      ex = (c - 2) / period;
      checks++;
      if (out_valid !== ev) begin
        failures++;
        $display("FAIL arith_g%0d_valid_c%0d: out_valid=%b, want %b", gap, c, out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (out_x !== 11'(ex) || out_sol !== (ex == 0)) begin
          failures++;
          $display("FAIL arith_g%0d_x%0d: out_x=%0d out_sol=%b, want %0d %b", gap, ex, out_x, out_sol, ex, (ex == 0));
        end
        if (ex == 0 || ex == 1 || ex == 5) begin
          case (ex)
            0:       exp_bus = 64'h8888_8888_8888_8884;
            1:       exp_bus = 64'h8888_8888_8888_8843;
            default: exp_bus = 64'h8888_8888_8843_3232;
          endcase
          checks++;
          if (cost_bus !== exp_bus) begin
            failures++;
            $display("FAIL arith_g%0d_cost_x%0d: cost_bus=%h, want %h", gap, ex, cost_bus, exp_bus);
          end
        end
        have_last = 1;
        last_x = ex;
      end else if (have_last) begin
        checks++;
        if (out_x !== 11'(last_x)) begin
          failures++;
          $display("FAIL arith_g%0d_hold_c%0d: out_x=%0d, want %0d", gap, c, out_x, last_x);
        end
      end
      dv = (c % period == 0) && (c / period < 8);
      bi = c / period;
      drive(dv, dv && bi == 0, 8'h0F, 8'(bi));
      step();
    end
  endtask

  task automatic test_restart();
    for (int k = 0; k < 14; k++) begin
      int b, x;
      b = k - 2;
      x = (b < 10) ? b : b - 10;
      checks++;
      if (k >= 2) begin
        if (out_valid !== 1'b1 || out_x !== 11'(x) || out_sol !== (x == 0) || cost_bus !== match_bus(x)) begin
          failures++;
          $display("FAIL restart_beat%0d: out_valid=%b out_x=%0d out_sol=%b cost_bus=%h, want 1 %0d %b %h",
                   b, out_valid, out_x, out_sol, cost_bus, x, (x == 0), match_bus(x));
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL restart_idle_k%0d: out_valid=%b, want 0", k, out_valid);
      end
      drive(k < 12, k == 0 || k == 10, 8'h3C, 8'h3C);
      step();
    end
  endtask

  task automatic test_reset_midline();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k == 0, 8'h3C, 8'h3C);
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || out_x !== 11'd6) begin
      failures++;
      $display("FAIL midrst_pre: out_valid=%b out_x=%0d, want 1 6", out_valid, out_x);
    end
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h3C, 8'h3C);
    step();
    checks++;
    if (out_valid !== 1'b0 || out_x !== 11'd0 || cost_bus !== 64'd0) begin
      failures++;
      $display("FAIL midrst_kill: out_valid=%b out_x=%0d cost_bus=%h, want 0 0 0", out_valid, out_x, cost_bus);
    end
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h3C, 8'h3C);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_dropped: out_valid=%b, want 0", out_valid);
    end
    drive(1'b1, 1'b0, 8'h3C, 8'h3C);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_x !== 11'd0 || cost_bus !== 64'h8888_8888_8888_8880) begin
      failures++;
      $display("FAIL midrst_first: out_valid=%b out_x=%0d cost_bus=%h, want 1 0 8888888888888880",
               out_valid, out_x, cost_bus);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_x !== 11'd1 || cost_bus !== 64'h8888_8888_8888_8800) begin
      failures++;
      $display("FAIL midrst_second: out_valid=%b out_x=%0d cost_bus=%h, want 1 1 8888888888888800",
               out_valid, out_x, cost_bus);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_tail: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_identical();
    drain();
    test_arith(0);
    drain();
    test_arith(1);
    drain();
    test_restart();
    drain();
    test_reset_midline();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
